// File: rtl/n8877_img.sv
// MB8877-style floppy controller: CPU-side register set with sector data backed by a
// linear disk-image memory. One access per cs assertion; type II data moves become memory cycles.
module n8877_img #(
  parameter int                        DRV_BITS  = 2,
  parameter int                        SPT_BITS  = 4,
  parameter int                        SECT_BITS = 8,
  parameter logic [(1<<DRV_BITS)-1:0]  DEF_WP    = '0,
  parameter logic [7:0]                BUSFREE   = 8'h00,
  parameter int                        MA_W      = DRV_BITS+8+SPT_BITS+SECT_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs,
  input  logic [2:0]      addr,
  input  logic            wr,
  input  logic [7:0]      wdata,
  output logic [7:0]      rdata,
  output logic            wait_n,
  output logic            intr,
  output logic [MA_W-1:0] maddr,
  output logic            mreq,
  output logic            mwe,
  output logic [1:0]      mbe,
  output logic [15:0]     mwdata,
  input  logic [15:0]     mrdata,
  input  logic            mack
);

  localparam int         NDRV  = 1 << DRV_BITS;
  localparam logic [8:0] NSECT = 9'(1 << SPT_BITS);

  typedef enum logic [2:0] {IDLE, REG, MRD, MWR, ADV} state_t;

  state_t                  state;
  logic                    cs_s, cs_d, cs_rise;
  logic [NDRV-1:0][7:0]    trk;
  logic [7:0]              sector, data, cmd, rdata_r, cur_trk, stat, lane;
  logic [SECT_BITS-1:0]    byte_cnt;
  logic [SPT_BITS-1:0]     sec_idx;
  logic [DRV_BITS-1:0]     drv;
  logic                    head, busy, rnf, wperr, step_dir, intr_pend, wait_n_r;
  logic                    rd_mode, wr_mode, sec_bad;

  function automatic logic [7:0] step(input logic [7:0] t, input logic dir_in);
    if (dir_in) return (t == 8'hFF) ? t : t + 8'd1;
    return (t == 8'h00) ? t : t - 8'd1;
  endfunction

  assign cs_rise = cs_s & ~cs_d;
  assign cur_trk = trk[drv];
  assign sec_idx = SPT_BITS'(sector - 8'd1);
  assign maddr   = {drv, cur_trk[6:0], head, sec_idx, byte_cnt};
  assign lane    = maddr[0] ? mrdata[15:8] : mrdata[7:0];
  assign rd_mode = busy && cmd[7:5] == 3'b100;
  assign wr_mode = busy && cmd[7:5] == 3'b101;
  assign sec_bad = sector == 8'd0 || {1'b0, sector} > NSECT;
  // Status layout follows the last command class: type II shows error flags, all else type I.
  assign stat = (cmd[7:6] == 2'b10) ? {1'b0, wperr, 1'b0, rnf, 2'b00, busy, busy}
                                    : {1'b0, DEF_WP[drv], 1'b1, 2'b00, cur_trk == 8'd0, 1'b1, busy};
  assign rdata  = cs ? rdata_r : BUSFREE;
  assign wait_n = cs ? wait_n_r : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cs_s      <= 1'b0;
      cs_d      <= 1'b0;
      trk       <= '0;
      sector    <= 8'd1;
      data      <= 8'hE5;
      cmd       <= 8'h00;
      rdata_r   <= BUSFREE;
      byte_cnt  <= '0;
      drv       <= '0;
      head      <= 1'b0;
      busy      <= 1'b0;
      rnf       <= 1'b0;
      wperr     <= 1'b0;
      step_dir  <= 1'b1;
      intr_pend <= 1'b0;
      intr      <= 1'b0;
      wait_n_r  <= 1'b1;
      mreq      <= 1'b0;
      mwe       <= 1'b0;
      mbe       <= 2'b00;
      mwdata    <= 16'h0000;
    end else begin
      cs_s <= cs;
      cs_d <= cs_s;
      if (intr_pend) begin
        intr      <= 1'b1;
        intr_pend <= 1'b0;
      end
      case (state)
        IDLE: begin
          wait_n_r <= 1'b1;
          if (cs_rise) begin
            wait_n_r <= 1'b0;
            if (addr == 3'd3 && rd_mode) begin
              state <= MRD;
              mreq  <= 1'b1;
              mwe   <= 1'b0;
            end else if (addr == 3'd3 && wr_mode) begin
              state  <= MWR;
              mreq   <= 1'b1;
              mwe    <= 1'b1;
              mbe    <= maddr[0] ? 2'b10 : 2'b01;
              mwdata <= {wdata, wdata};
              data   <= wdata;
            end else begin
              state <= REG;
            end
          end
        end
        REG: begin
          state <= IDLE;
          case (addr)
            3'd0: if (wr) begin
              cmd  <= wdata;
              intr <= 1'b0;
              if (!wdata[7]) begin
                busy      <= 1'b0;
                intr_pend <= 1'b1;
                case (wdata[6:5])
                  2'b00:   trk[drv] <= wdata[4] ? data : 8'h00;
                  2'b01:   trk[drv] <= step(cur_trk, step_dir);
                  2'b10:   begin step_dir <= 1'b1; trk[drv] <= step(cur_trk, 1'b1); end
                  default: begin step_dir <= 1'b0; trk[drv] <= step(cur_trk, 1'b0); end
                endcase
              end else if (!wdata[6]) begin
                byte_cnt <= '0;
                rnf      <= 1'b0;
                wperr    <= 1'b0;
                if (sec_bad) begin
                  rnf  <= 1'b1;
                  busy <= 1'b0;
                  intr <= 1'b1;
                end else if (wdata[5] && DEF_WP[drv]) begin
                  wperr <= 1'b1;
                  busy  <= 1'b0;
                  intr  <= 1'b1;
                end else begin
                  busy <= 1'b1;
                end
              end else if (wdata[7:4] == 4'hD) begin
                // Force-interrupt: only the immediate-interrupt flag raises INTRQ.
                busy <= 1'b0;
                intr <= wdata[3];
              end else begin
                busy <= 1'b0;
                intr <= 1'b1;
              end
            end else begin
              rdata_r <= stat;
              intr    <= 1'b0;
            end
            3'd1: if (wr) trk[drv] <= wdata; else rdata_r <= cur_trk;
            3'd2: if (wr) sector <= wdata;   else rdata_r <= sector;
            3'd3: if (wr) data <= wdata;     else rdata_r <= data;
            default: if (wr) begin
              drv  <= wdata[DRV_BITS-1:0];
              head <= wdata[4];
            end else begin
              rdata_r <= BUSFREE;
            end
          endcase
        end
        MRD: if (mack) begin
          mreq    <= 1'b0;
          rdata_r <= lane;
          data    <= lane;
          state   <= ADV;
        end
        MWR: if (mack) begin
          mreq  <= 1'b0;
          mwe   <= 1'b0;
          mbe   <= 2'b00;
          state <= ADV;
        end
        ADV: begin
          state    <= IDLE;
          byte_cnt <= byte_cnt + 1'b1;
          if (&byte_cnt) begin
            if (cmd[4] && {1'b0, sector} < NSECT) begin
              sector <= sector + 8'd1;
            end else begin
              busy <= 1'b0;
              intr <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/n8877_img.md
Name: n8877_img

Overview:
Parametrised successor to the read-only fake MB8877 FDC. It models the MB8877 register set on the CPU side and backs sector data with a linear disk-image memory, with both read and write paths. It adds multi-drive images, configurable geometry, multi-sector transfers, per-drive track registers, write protect, record-not-found and an interrupt output. It sits between the CPU I/O decoder (FDC port window) and the SDRAM/image arbiter.

Parameters:
DRV_BITS, 2, log2 of drive count; drive select field width.
SPT_BITS, 4, log2 of sectors per track; legal sectors are 1..2^SPT_BITS.
SECT_BITS, 8, log2 of sector size in bytes (256-byte sectors).
DEF_WP, {2^DRV_BITS{1'b0}}, per-drive write-protect bit, bit n = drive n.
BUSFREE, 8'h00, rdata value when cs=0.
MA_W, DRV_BITS+8+SPT_BITS+SECT_BITS, image byte-address width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cs  in  1  CPU chip select, held for the whole access
addr  in  3  0 cmd/stat, 1 track, 2 sector, 3 data, 4-7 drive ctl
wr  in  1  1 = write access, valid with cs
wdata  in  8  CPU write data
rdata  out  8  CPU read data; BUSFREE when cs=0
wait_n  out  1  CPU wait, low = stall; forced 1 when cs=0
intr  out  1  MB8877 INTRQ, active high
maddr  out  MA_W  image byte address
mreq  out  1  memory request, held until mack
mwe  out  1  1 = write cycle, valid with mreq
mbe  out  2  byte enables: 01 = even byte, 10 = odd byte
mwdata  out  16  write data, byte duplicated on both lanes
mrdata  in  16  read data, valid on the mack cycle
mack  in  1  single-cycle memory acknowledge

Behaviour:
- Reset (async): wait_n=1 (cs=0), rdata=BUSFREE, intr=0, mreq=0, mwe=0, mbe=00, maddr=0. Track registers are 0 for all drives. sector=1, data=8'hE5, cmd=0, busy=0, drv=0, head=0. FSM is IDLE. Reset mid-transfer drops mreq on the same edge; a pending mack is ignored.
- CPU handshake: a 2-FF register on cs detects the rising edge and starts exactly one access per cs assertion.
  - wait_n_r goes low on the edge and returns high on the cycle after the access completes.
  - wait_n_r stays high until cs falls.
  - Register accesses complete in 2 cycles from the edge. Media data accesses complete on mack+1.
- Address mapping: maddr = {drv, track[6:0], head, sector-1 [SPT_BITS-1:0], byte_cnt[SECT_BITS-1:0]}. The odd/even lane is selected by maddr[0].
- FSM states:
  - IDLE: waiting for a cs edge.
  - REG: register read/write, 1 cycle.
  - MRD: mreq=1, mwe=0, waiting for mack. rdata takes the selected lane.
  - MWR: mreq=1, mwe=1, mbe from maddr[0], waiting for mack.
  - ADV: advance the byte counter, then return to IDLE.
- Data port while busy with a type II read (8x/9x): the access goes to MRD. While busy with a type II write (Ax/Bx): the access goes to MWR. When not busy, the access goes to REG and uses the data register.
- ADV on byte_cnt wrap (all ones):
  - cmd[4] (m) = 1 and sector < 2^SPT_BITS: sector += 1, byte_cnt = 0, busy stays 1.
  - Otherwise: busy=0, intr=1. The sector register is unchanged (the last sector is kept).
- Command write (addr 0), per drive:
  - Type I 0x/1x/2x-7x: restore, seek, step, step-in or step-out on the track register of drive drv. Step-out saturates at 0; step-in saturates at 8'hFF. busy is never set; intr=1 one cycle later.
  - Type II 8x-Bx: byte_cnt=0, busy=1.
    - If sector=0 or sector > 2^SPT_BITS: RNF=1, busy=0, intr=1 immediately.
    - If it is a write command and WP[drv]=1: status WP=1, busy=0, intr=1, and no memory cycle occurs.
  - Cx/Ex/Fx: accepted and complete immediately with intr=1. They are not emulated.
  - D0: busy=0, intr=0. D8: busy=0, intr=1.
- intr clears on a status read or on any command write other than D8.
- A CPU command write accepted while busy overrides the current command. A D0 mid-sector aborts the command with byte_cnt retained; it is reset by the next type II command.
- Status bits:
  - Type I: {0, WP[drv], 1, 0, 0, track==0, 1, busy}.
  - Type II: {0, WPerr, 0, RNF, 0, 0, busy, busy}; DRQ mirrors busy.
- Drive ctl write (addr 4-7): drv = wdata[DRV_BITS-1:0], head = wdata[4]. A drive ctl read returns BUSFREE.
- The track port reads and writes the track register of the selected drive.

Test Plan:
- Reset, then read stat (addr 0) -> 8'h26 (WP=0, track00=1, index=1); wait_n low for 2 cycles; intr=0.
- drv=1, head=1, track write 5, sector 3, command 8'h80, then 256 data reads with 1-cycle mack -> maddr starts at {1, 7'd5, 1, 4'd2, 8'h00}. Each byte is the correct mrdata lane. busy drops and intr rises after byte 255.
- sector 16, command 8'h90 (multi-sector) -> after 256 bytes busy=0, intr=1, sector=16. Sector 15 with 8'h90 -> sector steps to 16 and the transfer runs 512 bytes.
- DEF_WP=4'b0010, drv=1, command 8'hA0 -> stat = 8'h40, intr=1, mreq never asserted. drv=0 with 8'hA0 -> 256 MWR cycles with mbe alternating 01/10.
- Sector 0 with 8'h80 -> stat bit4 (RNF)=1, busy=0. Step-out (8'h60) at track 0 -> track stays 0.
- Assert rst_n low during MRD with mreq=1 -> mreq=0 asynchronously. Next cs access sees the reset register values.
